// File: rtl/c_drain_stream.sv
// C result buffer drain: walks an MxN sub-block of the row-major C buffer through a
// 1-cycle-latency read port and emits each word on a valid/ready stream with a last flag.
module c_drain_stream #(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int AW    = $clog2(N*N),
  parameter int DW    = $clog2(N+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DW-1:0]    m_dim,
  input  logic [DW-1:0]    n_dim,
  output logic             busy,
  output logic             drain_done,
  output logic             c_rd_en,
  output logic [AW-1:0]    c_rd_addr,
  input  logic [ACC_W-1:0] c_rd_data,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [ACC_W-1:0] c_data,
  output logic             c_last
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t          state;
  logic [DW-1:0]   m_q, n_q, row, col;
  logic [ACC_W-1:0] fifo_data [2];
  logic            fifo_last [2];
  logic            rptr, wptr;
  logic [1:0]      fifo_cnt;
  logic            inflight, inflight_last;
  logic            push, pop, last_rd;
  logic [2:0]      occ;
  logic [DW-1:0]   m_clamp, n_clamp;

  function automatic logic [DW-1:0] clamp(input logic [DW-1:0] d);
    return (d > DW'(N)) ? DW'(N) : d;
  endfunction

  assign m_clamp = clamp(m_dim);
  assign n_clamp = clamp(n_dim);

  assign pop  = c_valid & c_ready;
  assign push = inflight;

  // Credit check counts the word leaving this cycle, so a full FIFO can still refill at rate.
  assign occ     = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign c_rd_en = (state == RUN) && (occ < 3'd2);
  assign last_rd = (row == m_q - DW'(1)) && (col == n_q - DW'(1));
  assign c_rd_addr = AW'(row * N + col);

  assign c_valid    = (fifo_cnt != 2'd0);
  assign c_data     = fifo_data[rptr];
  assign c_last     = fifo_last[rptr] & c_valid;
  assign busy       = (state != IDLE);
  assign drain_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      m_q           <= '0;
      n_q           <= '0;
      row           <= '0;
      col           <= '0;
      rptr          <= 1'b0;
      wptr          <= 1'b0;
      fifo_cnt      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      inflight      <= c_rd_en;
      inflight_last <= c_rd_en & last_rd;

      // Returning read data always has a slot: the credit check reserved it at issue.
      if (push) begin
        fifo_data[wptr] <= c_rd_data;
        fifo_last[wptr] <= inflight_last;
        wptr            <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};

      case (state)
        IDLE: if (start) begin
          m_q   <= m_clamp;
          n_q   <= n_clamp;
          row   <= '0;
          col   <= '0;
          state <= (m_clamp == '0 || n_clamp == '0) ? DONE : RUN;
        end
        RUN: if (c_rd_en) begin
          if (col == n_q - DW'(1)) begin
            col <= '0;
            row <= row + DW'(1);
          end else begin
            col <= col + DW'(1);
          end
          if (last_rd) state <= FLUSH;
        end
        FLUSH: if (!inflight && (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && pop)))
          state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c_drain_stream.sv
// Bench for c_drain_stream: queue-based reference of the drain order, random back-pressure.
module tb_c_drain_stream;
  localparam int N = 4, ACC_W = 32, AW = 4, DW = 3;

  logic             clk = 1'b0, rst_n;
  logic             start;
  logic [DW-1:0]    m_dim, n_dim;
  logic             busy, drain_done, c_rd_en, c_valid, c_ready, c_last;
  logic [AW-1:0]    c_rd_addr;
  logic [ACC_W-1:0] c_rd_data, c_data;

  c_drain_stream #(.N(N), .ACC_W(ACC_W), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m_dim(m_dim), .n_dim(n_dim),
    .busy(busy), .drain_done(drain_done), .c_rd_en(c_rd_en), .c_rd_addr(c_rd_addr),
    .c_rd_data(c_rd_data), .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .c_last(c_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ACC_W-1:0] cmem [N*N];
  always @(posedge clk) if (c_rd_en) c_rd_data <= cmem[c_rd_addr];

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Back-pressure driver: single owner of c_ready.
  bit rnd_ready = 0, ready_fix = 1;
  always begin
    @(posedge clk); #1;
    c_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  // Observed traffic
  int               rd_addr_q[$], rd_cyc_q[$], hs_cyc_q[$], done_cyc_q[$];
  logic [ACC_W-1:0] hs_data_q[$];
  bit               hs_last_q[$];
  int               busy_at[int];
  int               issued = 0, hsn = 0;
  logic             prev_stall = 0, prev_last, pop;
  logic [ACC_W-1:0] prev_data;

  always @(negedge clk) begin
    busy_at[cyc] = busy;
    if (!rst_n) begin
      issued = 0; hsn = 0; prev_stall = 0;
    end else begin
      pop = c_valid && c_ready;
      if (prev_stall) begin
        chk("stall_valid", c_valid, 1);
        chk("stall_data", c_data, prev_data);
        chk("stall_last", c_last, prev_last);
      end
      if (c_rd_en) begin
        chk("credit", ((issued - hsn - int'(pop)) < 2), 1);
        issued++;
        rd_addr_q.push_back(int'(c_rd_addr));
        rd_cyc_q.push_back(cyc);
      end
      if (pop) begin
        hsn++;
        hs_data_q.push_back(c_data);
        hs_last_q.push_back(c_last);
        hs_cyc_q.push_back(cyc);
      end
      if (drain_done) done_cyc_q.push_back(cyc);
      prev_stall = c_valid && !c_ready;
      prev_data  = c_data;
      prev_last  = c_last;
    end
  end

  task automatic clear_q();
    rd_addr_q.delete(); rd_cyc_q.delete(); hs_cyc_q.delete(); done_cyc_q.delete();
    hs_data_q.delete(); hs_last_q.delete();
  endtask

  // Start a drain; optionally re-pulse start with other dims 'repulse' cycles in.
  task automatic do_drain(input int m, input int n, input int repulse, output int c0);
    clear_q();
    @(posedge clk); #1;
    start = 1; m_dim = DW'(m); n_dim = DW'(n); c0 = cyc;
    @(posedge clk); #1;
    start = 0; m_dim = DW'($urandom); n_dim = DW'($urandom);
    if (repulse > 0) begin
      repeat (repulse - 1) @(posedge clk);
      #1 start = 1; m_dim = 3'd1; n_dim = 3'd1;
      @(posedge clk); #1 start = 0;
    end
    for (int k = 0; k < 300 && done_cyc_q.size() == 0; k++) @(posedge clk);
    chk("done_timeout", done_cyc_q.size() != 0, 1);
    repeat (3) @(posedge clk);
  endtask

  // Reference: row-major walk of the clamped sub-block, one beat per element.
  task automatic check_drain(input int m, input int n);
    int mc, nc, tot, exp_addr[$];
    mc = (m > N) ? N : m;
    nc = (n > N) ? N : n;
    for (int i = 0; i < mc; i++)
      for (int j = 0; j < nc; j++) exp_addr.push_back(i * N + j);
    tot = exp_addr.size();
    chk("n_reads", rd_addr_q.size(), tot);
    chk("n_beats", hs_data_q.size(), tot);
    chk("done_pulses", done_cyc_q.size(), 1);
    for (int k = 0; k < tot; k++) begin
      if (k < rd_addr_q.size()) chk("rd_addr", rd_addr_q[k], exp_addr[k]);
      if (k < hs_data_q.size()) begin
        chk("beat_data", hs_data_q[k], cmem[exp_addr[k]]);
        chk("beat_last", hs_last_q[k], (k == tot - 1));
      end
    end
  endtask

  task automatic rand_mem();
    for (int k = 0; k < N*N; k++) cmem[k] = $urandom;
  endtask

  initial begin
    int c0;
    rst_n = 0; start = 0; m_dim = '0; n_dim = '0;
    for (int k = 0; k < N*N; k++) cmem[k] = ACC_W'(k * 3 - 7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", drain_done, 0);
    chk("rst_rd_en", c_rd_en, 0);
    chk("rst_rd_addr", c_rd_addr, 0);
    chk("rst_valid", c_valid, 0);
    chk("rst_data", c_data, 0);
    chk("rst_last", c_last, 0);
    @(posedge clk); #1 rst_n = 1;

    // Full 4x4 at full rate, exact cycle timing
    do_drain(4, 4, 0, c0);
    check_drain(4, 4);
    if (rd_cyc_q.size() == 16 && hs_cyc_q.size() == 16 && done_cyc_q.size() == 1) begin
      chk("first_rd_cyc", rd_cyc_q[0], c0 + 1);
      chk("last_rd_cyc", rd_cyc_q[15], c0 + 16);
      chk("first_valid_cyc", hs_cyc_q[0], c0 + 3);
      chk("last_beat_cyc", hs_cyc_q[15], c0 + 18);
      chk("done_cyc", done_cyc_q[0], c0 + 19);
    end
    chk("busy_at_start", busy_at[c0], 0);
    chk("busy_after_start", busy_at[c0 + 1], 1);
    chk("busy_in_done", busy_at[c0 + 19], 1);
    chk("busy_after_done", busy_at[c0 + 20], 0);

    // Random back-pressure
    rnd_ready = 1;
    rand_mem();
    do_drain(4, 4, 0, c0);
    check_drain(4, 4);
    do_drain(2, 3, 0, c0);
    check_drain(2, 3);
    do_drain(7, 7, 0, c0);
    check_drain(7, 7);

    // Zero dimension: straight to DONE, no traffic
    do_drain(0, 4, 0, c0);
    check_drain(0, 4);
    if (done_cyc_q.size() == 1) chk("zero_done_cyc", done_cyc_q[0], c0 + 1);

    // start during RUN is ignored; next start after done is accepted
    do_drain(3, 2, 3, c0);
    check_drain(3, 2);
    do_drain(2, 2, 0, c0);
    check_drain(2, 2);

    for (int t = 0; t < 6; t++) begin
      int m, n;
      m = $urandom_range(0, 7);
      n = $urandom_range(0, 7);
      rand_mem();
      do_drain(m, n, 0, c0);
      check_drain(m, n);
    end

    // Reset mid-drain with the FIFO full
    rnd_ready = 0; ready_fix = 1;
    clear_q();
    @(posedge clk); #1 start = 1; m_dim = 3'd4; n_dim = 3'd4;
    @(posedge clk); #1 start = 0;
    for (int k = 0; k < 100 && hsn < 5; k++) @(posedge clk);
    chk("pre_reset_beats", hsn >= 5, 1);
    ready_fix = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_full", c_valid, 1);
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", drain_done, 0);
    chk("mid_rst_rd_en", c_rd_en, 0);
    chk("mid_rst_rd_addr", c_rd_addr, 0);
    chk("mid_rst_valid", c_valid, 0);
    chk("mid_rst_data", c_data, 0);
    chk("mid_rst_last", c_last, 0);
    ready_fix = 1;
    do_drain(4, 4, 0, c0);
    check_drain(4, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_chk, n_err);
    $fatal(1);
  end

endmodule
